// File: rtl/rggen_maskable_register_array_if.sv
// Bus-side handshake bundle for rggen_maskable_register_array.
// The master drives the request, and the register drives the response.
interface rggen_maskable_register_array_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                     valid;
    logic [1:0]               access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH-1:0]     strobe;
    logic                     active;
    logic                     ready;
    logic [1:0]               status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  active, ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output active, ready, status, read_data
    );
endinterface

// File: rtl/rggen_maskable_register_array.sv
// Multi-word maskable register: each bus word carries {mask, data}; supports ready latency and a hardware update port.
// Optional macro RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN adds o_write_event (the per-bit mask of the last bus commit).
`ifndef RGGEN_READ
`define RGGEN_READ 2'b10
`endif
`ifndef RGGEN_OKAY
`define RGGEN_OKAY 2'b00
`endif
`ifndef RGGEN_SLAVE_ERROR
`define RGGEN_SLAVE_ERROR 2'b10
`endif

module rggen_maskable_register_array #(
    parameter bit                       READABLE       = 1'b1,
    parameter bit                       WRITABLE       = 1'b1,
    parameter int                       ADDRESS_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter int                       BUS_WIDTH      = 32,
    parameter int                       DATA_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0]    INITIAL_VALUE  = '0,
    parameter int unsigned              READY_LATENCY  = 0
)(
    input  logic                             i_clk,
    input  logic                             i_rst,
    rggen_maskable_register_array_if.slave   register_if,
    output logic [DATA_WIDTH-1:0]            o_register_value,
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
    output logic [DATA_WIDTH-1:0]            o_write_event,
`endif
    input  logic                             i_hw_write_valid,
    input  logic [DATA_WIDTH-1:0]            i_hw_write_mask,
    input  logic [DATA_WIDTH-1:0]            i_hw_write_data
);
    localparam int H     = BUS_WIDTH / 2;
    localparam int WORDS = (DATA_WIDTH + H - 1) / H;
    localparam int BYTES = BUS_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int PW    = WORDS * H;
    localparam logic [3:0] LOAD = 4'(READY_LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state, state_next;
    logic [3:0]              count, count_next;
    logic [WORDS-1:0]        hit;
    logic                    active;
    logic                    is_read;
    logic                    ready;
    logic                    commit;
    logic [1:0]              status;
    logic [BUS_WIDTH-1:0]    read_data;
    logic [PW-1:0]           bm_pad, bd_pad, value_pad;
    logic [H-1:0]            rd_word;
    logic [DATA_WIDTH-1:0]   bus_mask, bus_data;
    logic [DATA_WIDTH-1:0]   value_q, value_next;
    logic                    unused;

    function automatic logic [ADDRESS_WIDTH-LSB-1:0] word_base(input int unsigned k);
        logic [ADDRESS_WIDTH-1:0] a;
        a = OFFSET_ADDRESS + ADDRESS_WIDTH'(k * BYTES);
        return a[ADDRESS_WIDTH-1:LSB];
    endfunction

    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            hit[k] = (register_if.address[ADDRESS_WIDTH-1:LSB] == word_base(k));
        end
    end

    assign active    = register_if.valid & (|hit);
    assign is_read   = (register_if.access == `RGGEN_READ);
    assign value_pad = PW'(value_q);

    // Words beyond DATA_WIDTH live in the padded vectors and are dropped on truncation.
    always_comb begin
        bm_pad  = '0;
        bd_pad  = '0;
        rd_word = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (hit[k]) begin
                bm_pad[k*H +: H] = register_if.write_data[BUS_WIDTH-1:H] & register_if.strobe[BUS_WIDTH-1:H];
                bd_pad[k*H +: H] = register_if.write_data[H-1:0];
                rd_word          = value_pad[k*H +: H];
            end
        end
    end

    assign bus_mask = bm_pad[DATA_WIDTH-1:0];
    assign bus_data = bd_pad[DATA_WIDTH-1:0];
    assign unused   = ^{register_if.address[LSB-1:0], register_if.strobe[H-1:0], bm_pad, bd_pad};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (active && (READY_LATENCY != 0)) begin
                    state_next = WAIT;
                    count_next = LOAD;
                end
            end
            WAIT: begin
                if (!active) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count == '0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        status    = `RGGEN_OKAY;
        read_data = '0;
        commit    = 1'b0;
        ready     = !i_rst && active &&
                    (((state == IDLE) && (READY_LATENCY == 0)) ||
                     ((state == WAIT) && (count == '0)));
        if (ready) begin
            if (is_read) begin
                if (READABLE) read_data = {{(BUS_WIDTH-H){1'b0}}, rd_word};
                else          status    = `RGGEN_SLAVE_ERROR;
            end else begin
                if (WRITABLE) commit = 1'b1;
                else          status = `RGGEN_SLAVE_ERROR;
            end
        end
    end

    assign register_if.active    = active;
    assign register_if.ready     = ready;
    assign register_if.status    = status;
    assign register_if.read_data = read_data;

    // Hardware update first, bus mask second: the bus wins on overlapping bits.
    always_comb begin
        value_next = value_q;
        if (i_hw_write_valid) begin
            value_next = (value_next & ~i_hw_write_mask) | (i_hw_write_data & i_hw_write_mask);
        end
        if (commit) begin
            value_next = (value_next & ~bus_mask) | (bus_data & bus_mask);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) value_q <= INITIAL_VALUE;
        else       value_q <= value_next;
    end

    assign o_register_value = value_q;

`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)       o_write_event <= '0;
        else if (commit) o_write_event <= bus_mask;
        else             o_write_event <= '0;
    end
`endif
endmodule

// File: tb/tb_rggen_maskable_register_array.sv
// Directed bench for rggen_maskable_register_array: four instances cover latency 0/2, WRITABLE=0 and READABLE=0.
// With RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN defined, o_write_event is checked as well.
module tb_rggen_maskable_register_array;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b11;
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        hv [4];
    logic [23:0] hm [4];
    logic [23:0] hd [4];
    logic [23:0] val [4];
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
    logic [23:0] wev [4];
`endif
    int total = 0;
    int bad   = 0;

    rggen_maskable_register_array_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) if0(), if1(), if2(), if3();

    rggen_maskable_register_array #(
        .DATA_WIDTH(24), .BUS_WIDTH(32), .ADDRESS_WIDTH(8), .INITIAL_VALUE(24'h0), .READY_LATENCY(0)
    ) u0 (
        .i_clk(clk), .i_rst(rst0), .register_if(if0.slave), .o_register_value(val[0]),
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        .o_write_event(wev[0]),
`endif
        .i_hw_write_valid(hv[0]), .i_hw_write_mask(hm[0]), .i_hw_write_data(hd[0])
    );

    rggen_maskable_register_array #(
        .DATA_WIDTH(24), .BUS_WIDTH(32), .ADDRESS_WIDTH(8), .INITIAL_VALUE(24'h0), .READY_LATENCY(2)
    ) u1 (
        .i_clk(clk), .i_rst(rst1), .register_if(if1.slave), .o_register_value(val[1]),
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        .o_write_event(wev[1]),
`endif
        .i_hw_write_valid(hv[1]), .i_hw_write_mask(hm[1]), .i_hw_write_data(hd[1])
    );

    rggen_maskable_register_array #(
        .WRITABLE(1'b0), .DATA_WIDTH(24), .BUS_WIDTH(32), .ADDRESS_WIDTH(8), .INITIAL_VALUE(24'h123456)
    ) u2 (
        .i_clk(clk), .i_rst(rst0), .register_if(if2.slave), .o_register_value(val[2]),
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        .o_write_event(wev[2]),
`endif
        .i_hw_write_valid(hv[2]), .i_hw_write_mask(hm[2]), .i_hw_write_data(hd[2])
    );

    rggen_maskable_register_array #(
        .READABLE(1'b0), .DATA_WIDTH(24), .BUS_WIDTH(32), .ADDRESS_WIDTH(8), .INITIAL_VALUE(24'h123456)
    ) u3 (
        .i_clk(clk), .i_rst(rst0), .register_if(if3.slave), .o_register_value(val[3]),
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        .o_write_event(wev[3]),
`endif
        .i_hw_write_valid(hv[3]), .i_hw_write_mask(hm[3]), .i_hw_write_data(hd[3])
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic drv(input int d, input logic v, input logic [1:0] acc,
                       input logic [7:0] a, input logic [31:0] wd, input logic [31:0] sb);
        case (d)
            0: begin if0.valid = v; if0.access = acc; if0.address = a; if0.write_data = wd; if0.strobe = sb; end
            1: begin if1.valid = v; if1.access = acc; if1.address = a; if1.write_data = wd; if1.strobe = sb; end
            2: begin if2.valid = v; if2.access = acc; if2.address = a; if2.write_data = wd; if2.strobe = sb; end
            default: begin if3.valid = v; if3.access = acc; if3.address = a; if3.write_data = wd; if3.strobe = sb; end
        endcase
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(i, 1'b0, RD, 8'h00, 32'h0, 32'h0);
            hv[i] = 1'b0;
            hm[i] = '0;
            hd[i] = '0;
        end
        repeat (2) @(posedge clk);
        at_neg();
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        chk("rst_val0", 32'(val[0]), 32'h0);
        chk("rst_val2", 32'(val[2]), 32'h123456);
        chk("rst_ready0", 32'(if0.ready), 32'h0);
        chk("rst_rdata0", if0.read_data, 32'h0);
        chk("rst_status0", 32'(if0.status), 32'(OK));
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        chk("rst_wev0", 32'(wev[0]), 32'h0);
`endif

        // ---- u0: latency 0 ----
        drv(0, 1'b1, WR, 8'h00, 32'h00FF_1234, ONES);
        #1;
        chk("w0_active", 32'(if0.active), 32'h1);
        chk("w0_ready", 32'(if0.ready), 32'h1);
        chk("w0_status", 32'(if0.status), 32'(OK));
        after_edge();
        chk("w0_value", 32'(val[0]), 32'h000034);
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        chk("w0_wev", 32'(wev[0]), 32'h0000FF);
`endif

        at_neg();
        drv(0, 1'b1, WR, 8'h04, 32'hFFFF_ABCD, ONES);
        #1;
        chk("w1_ready", 32'(if0.ready), 32'h1);
        after_edge();
        chk("w1_value", 32'(val[0]), 32'hCD0034);
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        chk("w1_wev", 32'(wev[0]), 32'hFF0000);
`endif

        at_neg();
        drv(0, 1'b1, RD, 8'h04, 32'h0, 32'h0);
        #1;
        chk("r1_ready", 32'(if0.ready), 32'h1);
        chk("r1_rdata", if0.read_data, 32'h0000_00CD);
        chk("r1_status", 32'(if0.status), 32'(OK));
        after_edge();
        chk("r1_value", 32'(val[0]), 32'hCD0034);
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        chk("r1_wev", 32'(wev[0]), 32'h0);
`endif

        at_neg();
        drv(0, 1'b1, RD, 8'h00, 32'h0, 32'h0);
        #1;
        chk("r0_rdata", if0.read_data, 32'h0000_0034);

        at_neg();
        drv(0, 1'b1, WR, 8'h00, 32'hFFFF_5678, 32'h00FF_FFFF);
        #1;
        chk("ws_ready", 32'(if0.ready), 32'h1);
        after_edge();
        chk("ws_value", 32'(val[0]), 32'hCD0078);

        at_neg();
        drv(0, 1'b1, RD, 8'h08, 32'h0, 32'h0);
        #1;
        chk("miss_active", 32'(if0.active), 32'h0);
        chk("miss_ready", 32'(if0.ready), 32'h0);
        chk("miss_rdata", if0.read_data, 32'h0);

        at_neg();
        drv(0, 1'b1, WR, 8'h00, 32'h000F_0005, ONES);
        hv[0] = 1'b1;
        hm[0] = 24'h0000FF;
        hd[0] = 24'h0000AA;
        after_edge();
        chk("hwbus_value", 32'(val[0]), 32'hCD00A5);
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        chk("hwbus_wev", 32'(wev[0]), 32'h00000F);
`endif

        at_neg();
        drv(0, 1'b0, RD, 8'h00, 32'h0, 32'h0);
        hm[0] = 24'hFF0000;
        hd[0] = 24'h110000;
        #1;
        chk("hw_ready", 32'(if0.ready), 32'h0);
        after_edge();
        chk("hw_value", 32'(val[0]), 32'h1100A5);
`ifdef RGGEN_MASKABLE_REGISTER_WRITE_EVENT_EN
        chk("hw_wev", 32'(wev[0]), 32'h0);
`endif

        at_neg();
        hv[0] = 1'b0;
        drv(0, 1'b1, RD, 8'h04, 32'h0, 32'h0);
        #1;
        chk("r2_rdata", if0.read_data, 32'h0000_0011);
        at_neg();
        drv(0, 1'b0, RD, 8'h00, 32'h0, 32'h0);

        // ---- u1: latency 2 ----
        drv(1, 1'b1, WR, 8'h00, 32'h00FF_0042, ONES);
        #1;
        chk("lat_c1_active", 32'(if1.active), 32'h1);
        chk("lat_c1_ready", 32'(if1.ready), 32'h0);
        after_edge();
        chk("lat_c1_value", 32'(val[1]), 32'h0);
        at_neg();
        #1;
        chk("lat_c2_ready", 32'(if1.ready), 32'h0);
        after_edge();
        at_neg();
        #1;
        chk("lat_c3_ready", 32'(if1.ready), 32'h1);
        chk("lat_c3_status", 32'(if1.status), 32'(OK));
        after_edge();
        chk("lat_value", 32'(val[1]), 32'h000042);

        at_neg();
        drv(1, 1'b1, WR, 8'h00, 32'h00FF_0099, ONES);
        #1;
        chk("abort_c1_ready", 32'(if1.ready), 32'h0);
        after_edge();
        at_neg();
        drv(1, 1'b0, WR, 8'h00, 32'h00FF_0099, ONES);
        #1;
        chk("abort_c2_ready", 32'(if1.ready), 32'h0);
        after_edge();
        chk("abort_value", 32'(val[1]), 32'h000042);

        at_neg();
        drv(1, 1'b1, WR, 8'h00, 32'h00FF_0077, ONES);
        #1;
        chk("reissue_c1_ready", 32'(if1.ready), 32'h0);
        after_edge();
        at_neg();
        #1;
        chk("reissue_c2_ready", 32'(if1.ready), 32'h0);
        after_edge();
        at_neg();
        #1;
        chk("reissue_c3_ready", 32'(if1.ready), 32'h1);
        after_edge();
        chk("reissue_value", 32'(val[1]), 32'h000077);

        at_neg();
        drv(1, 1'b1, WR, 8'h04, 32'hFFFF_00EE, ONES);
        #1;
        chk("rstw_c1_ready", 32'(if1.ready), 32'h0);
        after_edge();
        at_neg();
        rst1 = 1'b1;
        #1;
        chk("rstw_rst_ready", 32'(if1.ready), 32'h0);
        after_edge();
        chk("rstw_value", 32'(val[1]), 32'h0);
        at_neg();
        rst1 = 1'b0;
        #1;
        chk("rstw_n1_ready", 32'(if1.ready), 32'h0);
        after_edge();
        at_neg();
        #1;
        chk("rstw_n2_ready", 32'(if1.ready), 32'h0);
        after_edge();
        at_neg();
        #1;
        chk("rstw_n3_ready", 32'(if1.ready), 32'h1);
        after_edge();
        chk("rstw_n_value", 32'(val[1]), 32'hEE0000);
        at_neg();
        drv(1, 1'b0, RD, 8'h00, 32'h0, 32'h0);

        // ---- u2: WRITABLE=0 ----
        drv(2, 1'b1, WR, 8'h00, ONES, ONES);
        #1;
        chk("wro_ready", 32'(if2.ready), 32'h1);
        chk("wro_status", 32'(if2.status), 32'(SE));
        after_edge();
        chk("wro_value", 32'(val[2]), 32'h123456);
        at_neg();
        drv(2, 1'b1, RD, 8'h00, 32'h0, 32'h0);
        #1;
        chk("wro_rdata", if2.read_data, 32'h0000_3456);
        chk("wro_rstatus", 32'(if2.status), 32'(OK));
        at_neg();
        drv(2, 1'b0, RD, 8'h00, 32'h0, 32'h0);

        // ---- u3: READABLE=0 ----
        drv(3, 1'b1, RD, 8'h04, 32'h0, 32'h0);
        #1;
        chk("rdo_ready", 32'(if3.ready), 32'h1);
        chk("rdo_status", 32'(if3.status), 32'(SE));
        chk("rdo_rdata", if3.read_data, 32'h0);
        at_neg();
        drv(3, 1'b1, WR, 8'h04, 32'h00FF_0099, ONES);
        #1;
        chk("rdo_wstatus", 32'(if3.status), 32'(OK));
        after_edge();
        chk("rdo_value", 32'(val[3]), 32'h993456);
        at_neg();
        drv(3, 1'b0, RD, 8'h00, 32'h0, 32'h0);

        after_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
